// File: rtl/cdc_pkg.sv
// Shared types and limits for the clka->clkb word-transfer path.
package cdc_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_REQ,
      TX_RELEASE
   } cdc_tx_state_t;

   localparam int CDC_SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/cdc_sync_bit.sv
// N-stage single-bit synchronizer, async active-low reset to 0.
// Used for tx_ack on the source side and for tx_req on the receiver side.
module cdc_sync_bit #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst_b,
   input  logic d,
   output logic q
);

   logic [N-1:0] chain;

   // shift the asynchronous input through the flop chain
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) chain <= '0;
      else        chain <= {chain[N-2:0], d};
   end

   assign q = chain[N-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of the clka->clkb 4-phase req/ack word transfer.
// Optional input FIFO enabled by defining CDC_TX_BUFFER_EN; without it,
// a write is accepted only in IDLE with the synchronized ack low.
//
// state      | meaning
// -----------+-------------------------------------------------------
// TX_IDLE    | no transfer in flight; launch when a word is available
//            | and ack_s is low
// TX_REQ     | tx_req high, tx_data held; waiting for ack_s to rise
// TX_RELEASE | tx_req low, tx_data still held; waiting for ack_s to fall
module cdc_hs_tx
   import cdc_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int BUF_DEPTH   = 4
) (
   input  logic             clka,
   input  logic             rsta,
   input  logic [WIDTH-1:0] dataa,
   input  logic             new_dataa,
   output logic             readya,
   output logic             overflowa,
   output logic             busya,
   output logic [WIDTH-1:0] tx_data,
   output logic             tx_req,
   input  logic             tx_ack
);

   if (SYNC_STAGES < CDC_SYNC_STAGES_MIN) begin : g_bad_sync
      $error("cdc_hs_tx: SYNC_STAGES must be at least 2");
   end
   if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("cdc_hs_tx: BUF_DEPTH must be a power of 2, at least 2");
   end

   cdc_tx_state_t    state, state_nxt;
   logic             ack_s;
   logic             load;
   logic             word_avail;
   logic [WIDTH-1:0] word;

   cdc_sync_bit #(.N(SYNC_STAGES)) u_ack_sync (
      .clk   (clka),
      .rst_b (rsta),
      .d     (tx_ack),
      .q     (ack_s)
   );

`ifdef CDC_TX_BUFFER_EN
   localparam int AW = $clog2(BUF_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [BUF_DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             full, empty, push;

   // full when the wrap bits differ and the index bits match
   assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty      = (wr_ptr == rd_ptr);
   assign readya     = !full;
   assign push       = new_dataa && !full;
   assign word_avail = !empty;
   assign word       = mem[rd_ptr[AW-1:0]];

   // FIFO pointers; a pop is exactly a launch from IDLE
   always_ff @(posedge clka or negedge rsta) begin
      if (!rsta) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (load) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // FIFO storage, no reset needed since empty gates every read
   always_ff @(posedge clka) begin
      if (push) mem[wr_ptr[AW-1:0]] <= dataa;
   end
`else
   assign readya     = (state == TX_IDLE) && !ack_s;
   assign word_avail = new_dataa;
   assign word       = dataa;
`endif

   // next-state decode; load marks the IDLE->REQ launch
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      unique case (state)
         TX_IDLE: begin
            if (word_avail && !ack_s) begin
               load      = 1'b1;
               state_nxt = TX_REQ;
            end
         end
         TX_REQ: begin
            if (ack_s) state_nxt = TX_RELEASE;
         end
         TX_RELEASE: begin
            if (!ack_s) state_nxt = TX_IDLE;
         end
         default: state_nxt = TX_IDLE;
      endcase
   end

   // state register plus registered req and data bus
   always_ff @(posedge clka or negedge rsta) begin
      if (!rsta) begin
         state   <= TX_IDLE;
         tx_req  <= 1'b0;
         tx_data <= '0;
      end else begin
         state  <= state_nxt;
         tx_req <= (state_nxt == TX_REQ);
         if (load) tx_data <= word;
      end
   end

   // sticky flag for writes offered while not ready
   always_ff @(posedge clka or negedge rsta) begin
      if (!rsta)                      overflowa <= 1'b0;
      else if (new_dataa && !readya)  overflowa <= 1'b1;
   end

   assign busya = (state != TX_IDLE);

endmodule

// File: doc/cdc_hs_tx.md
# cdc_hs_tx

Source-side transmitter of the clka→clkb word-transfer path: accepts words from a clka-domain producer, holds each one stable on a registered bus and runs a 4-phase req/ack handshake against the clkb-domain receiver. The receiver synchronizes `tx_req`, captures `tx_data` and returns `tx_ack`, which this block synchronizes back into clka. An optional input FIFO decouples producer bursts from handshake latency.

## Interface
- WIDTH, 8, data word width
- SYNC_STAGES, 2, ack synchronizer depth (≥2)
- BUF_DEPTH, 4, input FIFO depth, power of 2 ≥2; used only with CDC_TX_BUFFER_EN

- clka  in  1  source clock
- rsta  in  1  reset, asynchronous, active-low; clock clka
- dataa  in  WIDTH  producer word
- new_dataa  in  1  write strobe, one word per clka cycle it is high
- readya  out  1  block accepts a write this cycle
- overflowa  out  1  sticky: write attempted while readya=0
- busya  out  1  handshake in progress (FSM not IDLE)
- tx_data  out  WIDTH  launched word, registered
- tx_req  out  1  request, registered, glitch-free
- tx_ack  in  1  acknowledge from clkb domain, asynchronous

## Operation
- tx_ack passes through a SYNC_STAGES flop chain → ack_s; the FSM uses only ack_s.
- FSM states:
  - IDLE: if a word is available and ack_s=0, load tx_data, set tx_req=1, go to REQ. A word available with ack_s=1 waits in IDLE; no launch.
  - REQ: hold tx_data and tx_req. When ack_s=1, set tx_req=0 and go to RELEASE.
  - RELEASE: when ack_s=0, go to IDLE.
- tx_data changes only on the IDLE→REQ edge. It stays stable until ack_s falls.
- A write with readya=0 is dropped and sets overflowa on the next edge. overflowa clears only by reset.
- busya = (state≠IDLE).

## Timing
- Reset values: tx_req=0, tx_data=0, busya=0, overflowa=0, readya=1, sync chain=0, FSM=IDLE, FIFO empty.
- Reset mid-handshake: tx_req falls asynchronously and the word in flight is lost. The system must reset the receiver together with this block.
- tx_ack rise → tx_req fall: SYNC_STAGES+1 clka edges. tx_ack fall → return to IDLE: SYNC_STAGES+1 edges.
- Without buffer:
  - new_dataa sampled at edge k → tx_req=1 and tx_data valid after k; readya=0 after k.
  - Back-to-back throughput with an immediate ack is 2·SYNC_STAGES+3 cycles per word (7 at default).
- With buffer:
  - write at edge k → entry valid after k; IDLE pops at k+1 → tx_req=1 after k+1.
  - Write and pop in the same cycle are both honoured.
  - readya = !full from the registered count. When full, a write is rejected even if a pop occurs that cycle.

## Configuration
- CDC_TX_BUFFER_EN defined:
  - BUF_DEPTH-entry FIFO between dataa and the FSM; readya = !full.
  - Pointers are log2(BUF_DEPTH)+1 bits wide and wrap. Full means the MSBs differ and the remaining bits are equal.
- CDC_TX_BUFFER_EN undefined:
  - No FIFO; readya = (state==IDLE && ack_s==0).
  - A write accepted in IDLE goes straight into tx_data. BUF_DEPTH is ignored.

## Structure
- Package cdc_pkg:
  - typedef enum logic [1:0] cdc_tx_state_t {TX_IDLE, TX_REQ, TX_RELEASE}
  - localparam CDC_SYNC_STAGES_MIN = 2
- Sub-module cdc_sync_bit: parameterised N-stage single-bit synchronizer with async active-low reset to 0. Instantiated once for tx_ack; the clkb side reuses it for tx_req.
- FIFO is inline, inside the CDC_TX_BUFFER_EN region.

## Test plan
- Reset release, then idle 10 cycles → tx_req=0, tx_data=0x00, readya=1, busya=0, overflowa=0.
- Write 0xA5; responder model raises tx_ack 3 clka after tx_req and drops it 3 clka after tx_req falls → tx_data=0xA5 stable throughout the handshake. Checks: tx_req falls 3 edges after tx_ack rise; readya returns 3 edges after tx_ack fall.
- Without buffer, write 0x11 then 0x22 one cycle later → 0x22 dropped, overflowa=1 and stays 1; only 0x11 is transferred.
- With buffer (BUF_DEPTH=4), burst 0x01..0x05 on consecutive cycles with ack stalled:
  - first word popped into tx_data; 0x02..0x05 fill the FIFO; readya=0.
  - a further write sets overflowa.
  - releasing ack delivers 0x01..0x05 in order.
- Hold tx_ack=1 through reset release, then write 0x3C → no tx_req while ack_s=1. tx_req rises on the edge after ack_s falls, not before.
- Assert rsta while in REQ → tx_req=0 and busya=0 immediately. After release, a new write 0x7E completes a normal handshake.
